rename_map_table: RTL and testbench

Parametrised register-alias (map) table for the out-of-order OTTER issue stage. Records which reservation-station tag will produce each architectural register, returns source tags to the issuing instruction, retires mappings from up to NCDB common-data-bus lanes, and drives the register-file write ports. It generalises the single-CDB map table with configurable register count, tag width and CDB lanes, plus stale-result filtering, same-cycle CDB bypass, an occupancy counter and optional branch checkpointing.

---
 rtl/rename_map_table_if.sv | 59 +++++
 rtl/rename_map_table.sv | 234 +++++++++++++++++++++++
 tb/tb_rename_map_table.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rename_map_table_if.sv
// rename_map_table_if: issue, lookup, CDB and register-file write signals of
// the rename map table. The issue stage/test driver uses the master modport,
// the map table uses the slave modport.
interface rename_map_table_if #(
    parameter int NREG  = 32,
    parameter int TAG_W = 4,
    parameter int NCDB  = 2
);
    localparam int AW = $clog2(NREG);
    localparam int CW = $clog2(NREG + 1);

    logic                  iss_valid;
    logic [AW-1:0]         iss_rd;
    logic [TAG_W-1:0]      iss_tag;

    logic [AW-1:0]         rs1_addr;
    logic [AW-1:0]         rs2_addr;
    logic                  rs1_used;
    logic                  rs2_used;
    logic [TAG_W-1:0]      t1;
    logic [TAG_W-1:0]      t2;
    logic                  fwd1;
    logic                  fwd2;
    logic [31:0]           fwd1_data;
    logic [31:0]           fwd2_data;

    logic [NCDB-1:0]       cdb_valid;
    logic [NCDB*TAG_W-1:0] cdb_tag;
    logic [NCDB*32-1:0]    cdb_data;

    logic [NCDB-1:0]       rf_we;
    logic [NCDB*AW-1:0]    rf_waddr;
    logic [NCDB*32-1:0]    rf_wdata;

    logic [CW-1:0]         busy_count;

    logic                  ckpt_save;
    logic                  ckpt_restore;

    modport master (
        output iss_valid, iss_rd, iss_tag,
        output rs1_addr, rs2_addr, rs1_used, rs2_used,
        input  t1, t2, fwd1, fwd2, fwd1_data, fwd2_data,
        output cdb_valid, cdb_tag, cdb_data,
        input  rf_we, rf_waddr, rf_wdata,
        input  busy_count,
        output ckpt_save, ckpt_restore
    );

    modport slave (
        input  iss_valid, iss_rd, iss_tag,
        input  rs1_addr, rs2_addr, rs1_used, rs2_used,
        output t1, t2, fwd1, fwd2, fwd1_data, fwd2_data,
        input  cdb_valid, cdb_tag, cdb_data,
        output rf_we, rf_waddr, rf_wdata,
        output busy_count,
        input  ckpt_save, ckpt_restore
    );
endinterface

// File: rtl/rename_map_table.sv
// rename_map_table: register-alias table for the out-of-order issue stage.
// Tracks the producing reservation-station tag per architectural register,
// answers source lookups with same-cycle CDB bypass, retires mappings from
// NCDB CDB lanes (ignoring stale tags) and drives registered RF write ports.
// Optional feature: define RMT_CHECKPOINT_EN for a single branch checkpoint
// (shadow copy of tag/busy with save/restore). Without it ckpt_* are ignored.
module rename_map_table #(
    parameter int NREG  = 32,
    parameter int TAG_W = 4,
    parameter int NCDB  = 2
) (
    input  logic                CLK,
    input  logic                RST_N,
    rename_map_table_if.slave   bus
);
    localparam int AW = $clog2(NREG);
    localparam int CW = $clog2(NREG + 1);

    logic [TAG_W-1:0] tag_q  [NREG];
    logic [NREG-1:0]  busy_q;
    logic [TAG_W-1:0] tag_d  [NREG];
    logic [NREG-1:0]  busy_d;

    // Table the next state is built from: live table, or shadow on restore.
    logic [TAG_W-1:0] base_tag [NREG];
    logic [NREG-1:0]  base_busy;

    logic [TAG_W-1:0] lane_tag  [NCDB];
    logic [31:0]      lane_data [NCDB];
    logic [NCDB-1:0]  lane_act;

    logic             restore_eff;
    logic             iss_eff;

    logic [NCDB-1:0]    rf_we_d;
    logic [AW-1:0]      rf_waddr_d [NCDB];
    logic [NCDB-1:0]    rf_we_q;
    logic [NCDB*AW-1:0] rf_waddr_q;
    logic [NCDB*32-1:0] rf_wdata_q;

    logic [CW-1:0]    cnt_d;
    logic [CW-1:0]    cnt_q;

    logic [AW-1:0]    src_addr [2];
    logic             src_used [2];
    logic [TAG_W-1:0] src_tag  [2];
    logic             src_fwd  [2];
    logic [31:0]      src_data [2];

    assign src_addr[0] = bus.rs1_addr;
    assign src_addr[1] = bus.rs2_addr;
    assign src_used[0] = bus.rs1_used;
    assign src_used[1] = bus.rs2_used;

    // A restore cycle discards the issue; issues to x0 never create a mapping.
    assign iss_eff = bus.iss_valid && !restore_eff && (bus.iss_rd != '0);

    // Unpack CDB lanes; a lane repeating a lower lane's tag is ignored.
    always_comb begin
        for (int i = 0; i < NCDB; i++) begin
            lane_tag[i]  = bus.cdb_tag[i*TAG_W +: TAG_W];
            lane_data[i] = bus.cdb_data[i*32 +: 32];
        end
        for (int i = 0; i < NCDB; i++) begin
            lane_act[i] = bus.cdb_valid[i];
            for (int j = 0; j < NCDB; j++) begin
                if (j < i && bus.cdb_valid[j] &&
                    (bus.cdb_tag[j*TAG_W +: TAG_W] == bus.cdb_tag[i*TAG_W +: TAG_W]))
                    lane_act[i] = 1'b0;
            end
        end
    end

    // Source lookups against pre-issue state with lowest-lane CDB bypass.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            src_tag[p]  = '0;
            src_fwd[p]  = 1'b0;
            src_data[p] = '0;
            if (src_used[p] && busy_q[src_addr[p]]) begin
                src_tag[p] = tag_q[src_addr[p]];
                for (int i = NCDB - 1; i >= 0; i--) begin
                    if (bus.cdb_valid[i] && (lane_tag[i] == tag_q[src_addr[p]])) begin
                        src_tag[p]  = '0;
                        src_fwd[p]  = 1'b1;
                        src_data[p] = lane_data[i];
                    end
                end
            end
        end
    end

    assign bus.t1        = src_tag[0];
    assign bus.t2        = src_tag[1];
    assign bus.fwd1      = src_fwd[0];
    assign bus.fwd2      = src_fwd[1];
    assign bus.fwd1_data = src_data[0];
    assign bus.fwd2_data = src_data[1];

    // RF write per lane: lowest live register holding the lane tag, unless
    // this cycle's issue is taking that register over (result is stale then).
    always_comb begin
        for (int i = 0; i < NCDB; i++) begin
            rf_we_d[i]    = 1'b0;
            rf_waddr_d[i] = '0;
            for (int r = NREG - 1; r >= 1; r--) begin
                if (lane_act[i] && busy_q[r] && (tag_q[r] == lane_tag[i]) &&
                    !(iss_eff && (bus.iss_rd == AW'(r)))) begin
                    rf_we_d[i]    = 1'b1;
                    rf_waddr_d[i] = AW'(r);
                end
            end
        end
    end

    // Next table: base table, CDB retires cleared, then issue overrides.
    always_comb begin
        cnt_d = '0;
        for (int r = 0; r < NREG; r++) begin
            tag_d[r]  = base_tag[r];
            busy_d[r] = base_busy[r];
            for (int i = 0; i < NCDB; i++) begin
                if (bus.cdb_valid[i] && busy_d[r] && (tag_d[r] == lane_tag[i])) begin
                    tag_d[r]  = '0;
                    busy_d[r] = 1'b0;
                end
            end
            if (iss_eff && (bus.iss_rd == AW'(r))) begin
                tag_d[r]  = bus.iss_tag;
                busy_d[r] = 1'b1;
            end
            if (r == 0) begin
                tag_d[r]  = '0;
                busy_d[r] = 1'b0;
            end
            cnt_d = cnt_d + CW'(busy_d[r]);
        end
    end

`ifdef RMT_CHECKPOINT_EN
    logic [TAG_W-1:0] sh_tag_q  [NREG];
    logic [NREG-1:0]  sh_busy_q;
    logic [TAG_W-1:0] sh_tag_d  [NREG];
    logic [NREG-1:0]  sh_busy_d;

    assign restore_eff = bus.ckpt_restore;

    // Restore rebuilds from the shadow; otherwise from the live table.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            base_tag[r]  = restore_eff ? sh_tag_q[r]  : tag_q[r];
            base_busy[r] = restore_eff ? sh_busy_q[r] : busy_q[r];
        end
    end

    // Shadow tracks retires; save (without restore) snapshots the next table.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            sh_tag_d[r]  = sh_tag_q[r];
            sh_busy_d[r] = sh_busy_q[r];
            for (int i = 0; i < NCDB; i++) begin
                if (bus.cdb_valid[i] && sh_busy_d[r] && (sh_tag_d[r] == lane_tag[i])) begin
                    sh_tag_d[r]  = '0;
                    sh_busy_d[r] = 1'b0;
                end
            end
            if (bus.ckpt_save && !restore_eff) begin
                sh_tag_d[r]  = tag_d[r];
                sh_busy_d[r] = busy_d[r];
            end
        end
    end

    // Shadow storage.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int r = 0; r < NREG; r++) sh_tag_q[r] <= '0;
            sh_busy_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) sh_tag_q[r] <= sh_tag_d[r];
            sh_busy_q <= sh_busy_d;
        end
    end
`else
    logic ckpt_unused;

    assign restore_eff = 1'b0;
    assign ckpt_unused = bus.ckpt_save ^ bus.ckpt_restore;

    // Without checkpointing the next table always starts from the live one.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            base_tag[r]  = tag_q[r];
            base_busy[r] = busy_q[r];
        end
    end
`endif

    // Map table and occupancy counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int r = 0; r < NREG; r++) tag_q[r] <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) tag_q[r] <= tag_d[r];
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Registered RF write ports; address/data only move on a real write.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rf_we_q    <= '0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q <= rf_we_d;
            for (int i = 0; i < NCDB; i++) begin
                if (rf_we_d[i]) begin
                    rf_waddr_q[i*AW +: AW] <= rf_waddr_d[i];
                    rf_wdata_q[i*32 +: 32] <= lane_data[i];
                end
            end
        end
    end

    assign bus.rf_we      = rf_we_q;
    assign bus.rf_waddr   = rf_waddr_q;
    assign bus.rf_wdata   = rf_wdata_q;
    assign bus.busy_count = cnt_q;

endmodule

// File: tb/tb_rename_map_table.sv
module tb_rename_map_table;
    logic CLK;
    logic RST_N;
    int   total;
    int   passed;

    rename_map_table_if #(.NREG(32), .TAG_W(4), .NCDB(2)) bus ();

    rename_map_table #(.NREG(32), .TAG_W(4), .NCDB(2)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", name, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.iss_valid    = 1'b0;
        bus.iss_rd       = '0;
        bus.iss_tag      = '0;
        bus.cdb_valid    = '0;
        bus.cdb_tag      = '0;
        bus.cdb_data     = '0;
        bus.ckpt_save    = 1'b0;
        bus.ckpt_restore = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [3:0] tag);
        bus.iss_valid = 1'b1;
        bus.iss_rd    = rd;
        bus.iss_tag   = tag;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        RST_N  = 1'b0;
        idle();
        bus.rs1_addr = '0;
        bus.rs2_addr = '0;
        bus.rs1_used = 1'b0;
        bus.rs2_used = 1'b0;
        #2;
        chk("reset_rf_we", 32'(bus.rf_we), 32'd0);
        chk("reset_busy_count", 32'(bus.busy_count), 32'd0);
        chk("reset_rf_wdata0", bus.rf_wdata[31:0], 32'd0);
        #10;
        RST_N = 1'b1;
        tick();

        // issue x5 <- tag 3; lookup in the same cycle sees the old state
        issue(5'd5, 4'd3);
        bus.rs1_addr = 5'd5;
        bus.rs1_used = 1'b1;
        #1;
        chk("same_cycle_t1", 32'(bus.t1), 32'd0);
        tick();
        idle();
        #1;
        chk("issue_t1", 32'(bus.t1), 32'd3);
        chk("issue_fwd1", 32'(bus.fwd1), 32'd0);
        chk("issue_busy_count", 32'(bus.busy_count), 32'd1);

        // CDB lane 0 retires tag 3
        bus.cdb_valid = 2'b01;
        bus.cdb_tag   = {4'd0, 4'd3};
        bus.cdb_data  = {32'd0, 32'hDEADBEEF};
        #1;
        chk("bypass_t1", 32'(bus.t1), 32'd0);
        chk("bypass_fwd1", 32'(bus.fwd1), 32'd1);
        chk("bypass_fwd1_data", bus.fwd1_data, 32'hDEADBEEF);
        tick();
        idle();
        chk("retire_rf_we", 32'(bus.rf_we), 32'b01);
        chk("retire_rf_waddr0", 32'(bus.rf_waddr[4:0]), 32'd5);
        chk("retire_rf_wdata0", bus.rf_wdata[31:0], 32'hDEADBEEF);
        chk("retire_busy_count", 32'(bus.busy_count), 32'd0);
        chk("retire_t1", 32'(bus.t1), 32'd0);
        tick();
        chk("rf_we_one_cycle", 32'(bus.rf_we), 32'd0);

        // stale result: x7 <- 2 then x7 <- 4
        issue(5'd7, 4'd2);
        tick();
        issue(5'd7, 4'd4);
        tick();
        idle();
        bus.rs1_addr = 5'd7;
        chk("remap_busy_count", 32'(bus.busy_count), 32'd1);
        #1;
        chk("remap_t1", 32'(bus.t1), 32'd4);
        bus.cdb_valid = 2'b01;
        bus.cdb_tag   = {4'd0, 4'd2};
        bus.cdb_data  = {32'd0, 32'h11111111};
        tick();
        idle();
        chk("stale_rf_we", 32'(bus.rf_we), 32'd0);
        chk("stale_t1", 32'(bus.t1), 32'd4);
        chk("stale_busy_count", 32'(bus.busy_count), 32'd1);
        bus.cdb_valid = 2'b10;
        bus.cdb_tag   = {4'd4, 4'd0};
        bus.cdb_data  = {32'h22222222, 32'd0};
        tick();
        idle();
        chk("lane1_rf_we", 32'(bus.rf_we), 32'b10);
        chk("lane1_rf_waddr1", 32'(bus.rf_waddr[9:5]), 32'd7);
        chk("lane1_rf_wdata1", bus.rf_wdata[63:32], 32'h22222222);
        chk("lane1_busy_count", 32'(bus.busy_count), 32'd0);

        // lane 1 bypass to rs2
        issue(5'd9, 4'd6);
        tick();
        idle();
        bus.rs1_used  = 1'b0;
        bus.rs2_addr  = 5'd9;
        bus.rs2_used  = 1'b1;
        #1;
        chk("rs2_t2", 32'(bus.t2), 32'd6);
        chk("rs1_unused_t1", 32'(bus.t1), 32'd0);
        bus.cdb_valid = 2'b10;
        bus.cdb_tag   = {4'd6, 4'd0};
        bus.cdb_data  = {32'h00000055, 32'd0};
        #1;
        chk("fwd2_t2", 32'(bus.t2), 32'd0);
        chk("fwd2_flag", 32'(bus.fwd2), 32'd1);
        chk("fwd2_data", bus.fwd2_data, 32'h55);
        bus.rs2_used = 1'b0;
        #1;
        chk("rs2_unused_fwd2", 32'(bus.fwd2), 32'd0);
        tick();
        idle();
        chk("fwd2_retire_rf_we", 32'(bus.rf_we), 32'b10);
        chk("fwd2_retire_waddr1", 32'(bus.rf_waddr[9:5]), 32'd9);

        // issue wins over a same-cycle retire of the old tag
        issue(5'd4, 4'd1);
        tick();
        issue(5'd4, 4'd5);
        bus.cdb_valid = 2'b01;
        bus.cdb_tag   = {4'd0, 4'd1};
        bus.cdb_data  = {32'd0, 32'h33333333};
        tick();
        idle();
        bus.rs1_addr = 5'd4;
        bus.rs1_used = 1'b1;
        chk("collide_rf_we", 32'(bus.rf_we), 32'd0);
        chk("collide_busy_count", 32'(bus.busy_count), 32'd1);
        #1;
        chk("collide_t1", 32'(bus.t1), 32'd5);
        issue(5'd0, 4'd7);
        tick();
        idle();
        bus.rs2_addr = 5'd0;
        bus.rs2_used = 1'b1;
        chk("x0_busy_count", 32'(bus.busy_count), 32'd1);
        #1;
        chk("x0_t2", 32'(bus.t2), 32'd0);

        // two lanes carrying the same tag: only lane 0 writes
        issue(5'd10, 4'd8);
        tick();
        idle();
        chk("dup_busy_count", 32'(bus.busy_count), 32'd2);
        bus.cdb_valid = 2'b11;
        bus.cdb_tag   = {4'd8, 4'd8};
        bus.cdb_data  = {32'hBBBBBBBB, 32'hAAAAAAAA};
        tick();
        idle();
        chk("dup_rf_we", 32'(bus.rf_we), 32'b01);
        chk("dup_rf_waddr0", 32'(bus.rf_waddr[4:0]), 32'd10);
        chk("dup_rf_wdata0", bus.rf_wdata[31:0], 32'hAAAAAAAA);
        chk("dup_busy_after", 32'(bus.busy_count), 32'd1);

`ifdef RMT_CHECKPOINT_EN
        // checkpoint: x1<-1, save, x2<-2, retire tag 1, restore
        issue(5'd1, 4'd1);
        tick();
        idle();
        bus.ckpt_save = 1'b1;
        tick();
        idle();
        issue(5'd2, 4'd2);
        tick();
        idle();
        chk("ckpt_pre_busy", 32'(bus.busy_count), 32'd3);
        bus.cdb_valid = 2'b01;
        bus.cdb_tag   = {4'd0, 4'd1};
        tick();
        idle();
        bus.ckpt_restore = 1'b1;
        tick();
        idle();
        chk("ckpt_busy_count", 32'(bus.busy_count), 32'd1);
        bus.rs1_addr = 5'd1;
        bus.rs2_addr = 5'd2;
        #1;
        chk("ckpt_x1_free", 32'(bus.t1), 32'd0);
        chk("ckpt_x2_free", 32'(bus.t2), 32'd0);
        bus.rs1_addr = 5'd4;
        #1;
        chk("ckpt_x4_kept", 32'(bus.t1), 32'd5);
`endif

        // async reset mid-stream with rf_we high
        issue(5'd11, 4'd9);
        tick();
        idle();
        bus.cdb_valid = 2'b01;
        bus.cdb_tag   = {4'd0, 4'd9};
        bus.cdb_data  = {32'd0, 32'h77777777};
        tick();
        idle();
        bus.rs1_addr = 5'd4;
        bus.rs1_used = 1'b1;
        #1;
        chk("pre_reset_rf_we", 32'(bus.rf_we), 32'b01);
        chk("pre_reset_t1", 32'(bus.t1), 32'd5);
        RST_N = 1'b0;
        #1;
        chk("async_rf_we", 32'(bus.rf_we), 32'd0);
        chk("async_t1", 32'(bus.t1), 32'd0);
        chk("async_busy_count", 32'(bus.busy_count), 32'd0);
        chk("async_rf_wdata0", bus.rf_wdata[31:0], 32'd0);
        #10;
        RST_N = 1'b1;
        tick();
        chk("post_reset_t1", 32'(bus.t1), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
